// File: rtl/bidir_bank_pkg.sv
// Shared definitions for the bidir_bank IO bank: mode names, width helper and
// the per-channel state record.
package bidir_bank_pkg;

    localparam string MODE_INPUT  = "INPUT";
    localparam string MODE_OUTPUT = "OUTPUT";
    localparam string MODE_INOUT  = "INOUT";

    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

    localparam int SYNC_MAX  = 4;
    localparam int DEB_MAX_W = clog2_min1(255);
    localparam int TURN_W    = 3;

    // Sized for the largest legal configuration; unused upper bits stay 0.
    typedef struct packed {
        logic [SYNC_MAX-1:0]  sync;
        logic [DEB_MAX_W-1:0] deb;
        logic [TURN_W-1:0]    turn;
    } ch_state_t;

endpackage

// File: rtl/bidir_bank_ch.sv
// One input channel: synchroniser, turnaround blanking, debounce filter and
// IQZ change pulse.
module bidir_bank_ch
    import bidir_bank_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 4,
    parameter int TURN_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic iqe,
    input  logic pad,
    input  logic inen,
    input  logic drv,
    input  logic drv_nxt,
    output logic iqz,
    output logic iedge
);

    localparam int DEB_W = clog2_min1(DEB_CYCLES);
    localparam logic [SYNC_MAX-1:0]  SYNC_TAP = SYNC_MAX'(1) << (SYNC_STAGES - 1);
    localparam logic [DEB_MAX_W-1:0] DEB_LAST = DEB_MAX_W'(DEB_CYCLES - 1);

    ch_state_t        st_q;
    ch_state_t        st_d;
    logic             iqz_d;
    logic             iedge_d;
    logic             s;
    logic             blank;
    logic [DEB_W-1:0] deb_cnt;

    always_comb begin
        s       = |(st_q.sync & SYNC_TAP);
        blank   = drv | ~inen | (st_q.turn != '0);
        deb_cnt = st_q.deb[DEB_W-1:0];
        st_d      = st_q;
        st_d.sync = {st_q.sync[SYNC_MAX-2:0], pad};
        iqz_d     = iqz;
        iedge_d   = 1'b0;
        if (iqe) begin
            // Own drive being released starts the turnaround window.
            if (drv && !drv_nxt)
                st_d.turn = TURN_W'(TURN_CYCLES);
            else if (st_q.turn != '0)
                st_d.turn = st_q.turn - 1'b1;

            if (blank || (s == iqz)) begin
                st_d.deb = '0;
            end else if (st_q.deb == DEB_LAST) begin
                st_d.deb = '0;
                iqz_d    = s;
                iedge_d  = 1'b1;
            end else begin
                st_d.deb = DEB_MAX_W'(deb_cnt + 1'b1);
            end
        end
    end

    // Stage boundary: channel state, filtered level and edge pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q  <= '0;
            iqz   <= 1'b0;
            iedge <= 1'b0;
        end else begin
            st_q  <= st_d;
            iqz   <= iqz_d;
            iedge <= iedge_d;
        end
    end

endmodule

// File: rtl/bidir_bank.sv
// NCH-channel bidirectional IO bank with registered output path and filtered
// inputs. Optional macro BIDIR_BANK_LOOPBACK_EN adds the LPBK self-test port.
module bidir_bank
    import bidir_bank_pkg::*;
#(
    parameter int    NCH         = 8,
    parameter string MODE        = "INOUT",
    parameter int    SYNC_STAGES = 2,
    parameter int    DEB_CYCLES  = 4,
    parameter int    TURN_CYCLES = 1
) (
    input  logic           IQC,
    input  logic           IQR,
    input  logic           IQE,
    input  logic [NCH-1:0] OQI,
    input  logic [NCH-1:0] OQE,
    input  logic [NCH-1:0] INEN,
    input  logic [NCH-1:0] I_PAD,
`ifdef BIDIR_BANK_LOOPBACK_EN
    input  logic           LPBK,
`endif
    output logic [NCH-1:0] O_PAD,
    output logic [NCH-1:0] O_EN,
    output logic [NCH-1:0] IZ,
    output logic [NCH-1:0] IQZ,
    output logic [NCH-1:0] IEDGE
);

    localparam bit HAS_OUT = (MODE != MODE_INPUT);
    localparam bit HAS_IN  = (MODE != MODE_OUTPUT);

    logic [NCH-1:0] o_pad_q;
    logic [NCH-1:0] o_en_q;
    logic [NCH-1:0] drv;
    logic [NCH-1:0] drv_nxt;
    logic [NCH-1:0] pad_src;

    generate
        if (HAS_OUT) begin : g_out
            // Stage boundary: fabric to pad registers
            always_ff @(posedge IQC or negedge IQR) begin
                if (!IQR) begin
                    o_pad_q <= '0;
                    o_en_q  <= '0;
                end else if (IQE) begin
                    o_pad_q <= OQI;
                    o_en_q  <= OQE;
                end
            end
        end else begin : g_no_out
            assign o_pad_q = '0;
            assign o_en_q  = '0;
        end
    endgenerate

`ifdef BIDIR_BANK_LOOPBACK_EN
    // Loopback feeds the output register back in and releases the pad.
    assign drv     = o_en_q & {NCH{~LPBK}};
    assign drv_nxt = OQE & {NCH{~LPBK}};
    assign pad_src = LPBK ? o_pad_q : I_PAD;
`else
    assign drv     = o_en_q;
    assign drv_nxt = OQE;
    assign pad_src = I_PAD;
`endif

    assign O_PAD = o_pad_q;
    assign O_EN  = drv;

    generate
        if (HAS_IN) begin : g_in
            assign IZ = I_PAD & INEN;
            for (genvar i = 0; i < NCH; i++) begin : g_ch
                bidir_bank_ch #(
                    .SYNC_STAGES(SYNC_STAGES),
                    .DEB_CYCLES (DEB_CYCLES),
                    .TURN_CYCLES(TURN_CYCLES)
                ) u_ch (
                    .clk    (IQC),
                    .rst_n  (IQR),
                    .iqe    (IQE),
                    .pad    (pad_src[i]),
                    .inen   (INEN[i]),
                    .drv    (drv[i]),
                    .drv_nxt(drv_nxt[i]),
                    .iqz    (IQZ[i]),
                    .iedge  (IEDGE[i])
                );
            end
        end else begin : g_no_in
            assign IZ    = '0;
            assign IQZ   = '0;
            assign IEDGE = '0;
        end
    endgenerate

endmodule

// File: tb/tb_bidir_bank.sv
// Directed bench for bidir_bank: expected IQZ-change events are queued by the
// stimulus and consumed by a monitor whenever IEDGE is seen.
module tb_bidir_bank;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       iqe;
    logic [7:0] oqi, oqe, inen, i_pad;
    logic       lpbk;
    logic [7:0] o_pad, o_en, iz, iqz, iedge;
    logic [7:0] oo_pad, oo_en, oo_iz, oo_iqz, oo_iedge;
    logic [7:0] io_pad, io_en, io_iz, io_iqz, io_iedge;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    bidir_bank #(.NCH(8), .MODE("INOUT"), .SYNC_STAGES(2), .DEB_CYCLES(4), .TURN_CYCLES(3)) u_dut (
        .IQC(clk), .IQR(rst_n), .IQE(iqe), .OQI(oqi), .OQE(oqe), .INEN(inen), .I_PAD(i_pad),
`ifdef BIDIR_BANK_LOOPBACK_EN
        .LPBK(lpbk),
`endif
        .O_PAD(o_pad), .O_EN(o_en), .IZ(iz), .IQZ(iqz), .IEDGE(iedge)
    );

    bidir_bank #(.NCH(8), .MODE("OUTPUT"), .SYNC_STAGES(2), .DEB_CYCLES(4), .TURN_CYCLES(3)) u_out (
        .IQC(clk), .IQR(rst_n), .IQE(iqe), .OQI(oqi), .OQE(oqe), .INEN(inen), .I_PAD(i_pad),
`ifdef BIDIR_BANK_LOOPBACK_EN
        .LPBK(lpbk),
`endif
        .O_PAD(oo_pad), .O_EN(oo_en), .IZ(oo_iz), .IQZ(oo_iqz), .IEDGE(oo_iedge)
    );

    bidir_bank #(.NCH(8), .MODE("INPUT"), .SYNC_STAGES(2), .DEB_CYCLES(4), .TURN_CYCLES(3)) u_in (
        .IQC(clk), .IQR(rst_n), .IQE(iqe), .OQI(oqi), .OQE(oqe), .INEN(inen), .I_PAD(i_pad),
`ifdef BIDIR_BANK_LOOPBACK_EN
        .LPBK(lpbk),
`endif
        .O_PAD(io_pad), .O_EN(io_en), .IZ(io_iz), .IQZ(io_iqz), .IEDGE(io_iedge)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Every IEDGE must match the next queued {iedge, iqz} expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && iedge !== 8'h00) begin
            if (exp_q.size() == 0) begin
                chk("iedge_unexpected", {24'h0, iedge}, 32'h0);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                chk("iedge_value", {24'h0, iedge}, {24'h0, e[15:8]});
                chk("iqz_at_iedge", {24'h0, iqz}, {24'h0, e[7:0]});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; iqe = 1'b1; oqi = 8'h00; oqe = 8'h00;
        inen = 8'hFF; i_pad = 8'h00; lpbk = 1'b0;
        repeat (3) step();
        chk("rst_o_pad", o_pad, 0);
        chk("rst_o_en",  o_en,  0);
        chk("rst_iqz",   iqz,   0);
        chk("rst_iedge", iedge, 0);
        rst_n = 1'b1;
        repeat (2) step();

        // Debounce on ch0, 3-cycle glitch on ch1, output register load
        i_pad = 8'h03; oqi = 8'h3C;
        step();
        chk("o_pad_load", o_pad, 8'h3C);
        repeat (2) step();
        i_pad = 8'h01;
        repeat (2) step();
        chk("iqz_pre_deb", iqz, 8'h00);
        exp_q.push_back({8'h01, 8'h01});
        step();
        chk("iqz_deb_rise", iqz, 8'h01);
        step();
        chk("iedge_one_cycle", iedge, 8'h00);
        chk("iz_direct", iz, 8'h01);
        chk("out_mode_iz", oo_iz, 8'h00);
        chk("out_mode_iqz", oo_iqz, 8'h00);
        repeat (3) step();
        chk("glitch_rejected", iqz, 8'h01);

        // Clock enable toggling 0,1,0,1...
        i_pad = 8'h00; oqi = 8'hF0; iqe = 1'b0;
        exp_q.push_back({8'h01, 8'h00});
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 1)  chk("o_pad_hold_iqe0", o_pad, 8'h3C);
            if (k == 2)  chk("o_pad_upd_iqe1", o_pad, 8'hF0);
            if (k == 9)  chk("iqz_ce_pre", iqz, 8'h01);
            if (k == 10) chk("iqz_ce_fall", iqz, 8'h00);
            iqe = (k % 2 == 1);
        end
        iqe = 1'b1;
        repeat (2) step();

        // Turnaround on ch2 with the pad already high
        oqe = 8'h04; i_pad = 8'h04;
        step();
        chk("o_en_drive", o_en, 8'h04);
        repeat (4) step();
        oqe = 8'h00;
        step();
        chk("o_en_release", o_en, 8'h00);
        repeat (6) step();
        chk("iqz_turn_hold", iqz, 8'h00);
        exp_q.push_back({8'h04, 8'h04});
        step();
        chk("iqz_turn_done", iqz, 8'h04);
        repeat (2) step();

        // INEN=0 blanks ch3
        inen = 8'hF7; i_pad = 8'h0C;
        step();
        chk("iz_gated", iz, 8'h04);
        repeat (7) step();
        chk("inen_blank", iqz, 8'h04);
        i_pad = 8'h04;
        repeat (3) step();
        inen = 8'hFF;
        repeat (5) step();
        chk("inen_restore", iqz, 8'h04);

        // Async reset mid-traffic: ch0 driving, ch2 high, ch4 mid-debounce
        oqe = 8'h01; i_pad = 8'h14;
        step();
        chk("pre_rst_o_en", o_en, 8'h01);
        repeat (3) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_o_pad", o_pad, 0);
        chk("async_rst_o_en",  o_en,  0);
        chk("async_rst_iqz",   iqz,   0);
        chk("async_rst_iedge", iedge, 0);
        i_pad = 8'h00; oqe = 8'h00; oqi = 8'h00;
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("post_rst_iedge", iedge, 0);
        end
        chk("post_rst_iqz", iqz, 0);

        // Mode gating with all enables and pads high
        oqe = 8'hFF; i_pad = 8'hFF;
        for (int k = 0; k < 8; k++) step();
        chk("in_mode_o_en", io_en, 8'h00);
        chk("out_mode_o_en", oo_en, 8'hFF);
        chk("out_mode_iz_hi", oo_iz, 8'h00);
        chk("out_mode_iqz_hi", oo_iqz, 8'h00);
        chk("out_mode_iedge_hi", oo_iedge, 8'h00);
        chk("own_drive_blank", iqz, 8'h00);

`ifdef BIDIR_BANK_LOOPBACK_EN
        lpbk = 1'b1; oqi = 8'hA5;
        step();
        chk("lpbk_o_en", o_en, 8'h00);
        chk("lpbk_o_pad", o_pad, 8'hA5);
        repeat (5) step();
        chk("lpbk_iqz_pre", iqz, 8'h00);
        exp_q.push_back({8'hA5, 8'hA5});
        step();
        chk("lpbk_iqz", iqz, 8'hA5);
        repeat (2) step();
`endif

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
